bm_loader: RTL and testbench

Fills one 1536-bit bitmap register in the CPU register file from data memory. The CPU issues a start with a base address and a destination bitmap index. The loader then fetches 96 consecutive 16-bit words and assembles them into a staging buffer. When all words are in, it commits the buffer in one cycle through the register file's wide write port (`wbm`/`wbm_addr`/`wbm_data`). The block sits between the data-memory read port and the register file's bitmap write port.

---
 rtl/bm_loader.sv | 108 ++++++++++
 tb/tb_bm_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_loader.sv
// bm_loader: streams 96 memory words into a staging buffer,
// then commits it to one bitmap register in a single write.
module bm_loader #(
  parameter int W     = 16,
  parameter int B     = 1536,
  parameter int WORDS = B / W,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [1:0]    dst,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          wbm,
  output logic [1:0]    wbm_addr,
  output logic [B-1:0]  wbm_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_COMMIT
  } state_e;

  localparam logic [6:0] LAST = 7'(WORDS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [1:0]    dst_q, dst_d;
  logic [6:0]    idx_q, idx_d;
  logic [B-1:0]  buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      dst_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dst_d   = dst_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        // dst 3 has no register behind it: drop the request
        if (start && dst != 2'd3) begin
          state_d = S_REQ;
          base_d  = base_addr;
          dst_d   = dst;
          idx_d   = '0;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          buf_d[W*idx_q +: W] = mem_rd_data;
          if (idx_q == LAST) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_REQ;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_rd_en = (state_q == S_REQ);
    mem_addr  = '0;
    if (mem_rd_en) begin
      mem_addr = base_q + AW'(idx_q);
    end
    wbm      = (state_q == S_COMMIT);
    done     = wbm;
    wbm_addr = wbm ? dst_q : 2'd0;
    wbm_data = buf_q;
  end

endmodule

// File: tb/tb_bm_loader.sv
// tb_bm_loader: directed loads against a transaction-level model
// of the loader and a latency-programmable memory responder.
module tb_bm_loader;

  localparam int W     = 16;
  localparam int B     = 1536;
  localparam int WORDS = 96;

  logic         clk          = 1'b0;
  logic         rst          = 1'b1;
  logic         start        = 1'b0;
  logic [15:0]  base_addr    = 16'h0;
  logic [1:0]   dst          = 2'd0;
  logic         busy;
  logic         done;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_rd_data  = 16'hDEAD;
  logic         mem_rd_valid = 1'b0;
  logic         wbm;
  logic [1:0]   wbm_addr;
  logic [B-1:0] wbm_data;

  bm_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .dst          (dst),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .wbm          (wbm),
    .wbm_addr     (wbm_addr),
    .wbm_data     (wbm_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int fails  = 0;

  // memory behaviour
  int          lat         = 1;
  bit          stall_on    = 1'b0;
  logic [15:0] stall_addr  = 16'h0;
  int          stall_extra = 0;
  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;
  pend_t pq[$];

  // model state
  bit          chk_en = 1'b0;
  bit          m_act  = 1'b0;
  bit          m_wait = 1'b0;
  int          m_words, m_req, m_commit;
  logic [15:0] m_base;
  logic [1:0]  m_dst;
  logic [15:0] m_img[WORDS];

  // observation logs
  int           wbm_n = 0;
  int           wbm_cyc = -1;
  logic [1:0]   wbm_a;
  logic [B-1:0] wbm_d;
  int           rq_cyc[$];
  logic [15:0]  rq_addr[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] qa(input int i);
    if (i >= 0 && i < rq_addr.size()) return rq_addr[i];
    return 16'hxxxx;
  endfunction

  function automatic int qc(input int i);
    if (i >= 0 && i < rq_cyc.size()) return rq_cyc[i];
    return -1;
  endfunction

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(input int c,
                             input logic [15:0] b,
                             input logic [1:0] d);
    at_cycle(c);
    start     = 1'b1;
    base_addr = b;
    dst       = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_wbm(input int n, input string nm);
    int k;
    k = 0;
    while (wbm_n < n && k < 1500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (wbm_n < n) begin
      fails++;
      $display("FAIL %s timeout: wbm count %0d want %0d",
               nm, wbm_n, n);
    end
  endtask

  function automatic int count_addr(input int from,
                                    input logic [15:0] a);
    int n;
    n = 0;
    for (int i = from; i < rq_addr.size(); i++)
      if (rq_addr[i] === a) n++;
    return n;
  endfunction

  int t0, t1, n0, r0;

  initial begin
    fork
      // memory responder: one reply per request after lat cycles
      forever begin : resp
        pend_t p;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'hDEAD;
        if (pq.size() > 0 && pq[0].due == cyc) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = pq[0].addr;
          void'(pq.pop_front());
        end
        if (mem_rd_en === 1'b1) begin
          p.addr = mem_addr;
          p.due  = cyc + lat;
          if (stall_on && mem_addr == stall_addr)
            p.due = p.due + stall_extra;
          pq.push_back(p);
        end
      end
      // per-cycle compare against the model
      forever begin : cmp
        logic        e_rd, e_cm;
        logic [15:0] e_addr;
        int          bad;
        @(negedge clk);
        #2;
        if (chk_en) begin
          e_rd   = m_act && (cyc == m_req);
          e_cm   = m_act && (cyc == m_commit);
          e_addr = e_rd ? m_base + 16'(m_words) : 16'h0;
          chk("busy", 32'(busy), 32'(m_act));
          chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
          chk("mem_addr", 32'(mem_addr), 32'(e_addr));
          chk("wbm", 32'(wbm), 32'(e_cm));
          chk("done", 32'(done), 32'(e_cm));
          chk("wbm_addr", 32'(wbm_addr),
              32'(e_cm ? m_dst : 2'd0));
          if (e_cm) begin
            bad = -1;
            for (int k = 0; k < WORDS; k++)
              if (bad < 0 && wbm_data[W*k +: W] !== m_img[k])
                bad = k;
            checks++;
            if (bad >= 0) begin
              fails++;
              $display("FAIL wbm_data word %0d: got %h want %h",
                       bad, wbm_data[W*bad +: W], m_img[bad]);
            end
          end
          if (mem_rd_en === 1'b1) begin
            rq_cyc.push_back(cyc);
            rq_addr.push_back(mem_addr);
          end
          if (wbm === 1'b1) begin
            wbm_n++;
            wbm_cyc = cyc;
            wbm_a   = wbm_addr;
            wbm_d   = wbm_data;
          end
          // advance the model across the coming edge
          if (rst) begin
            m_act = 1'b0;
          end else if (!m_act) begin
            if (start && dst != 2'd3) begin
              m_act    = 1'b1;
              m_wait   = 1'b0;
              m_base   = base_addr;
              m_dst    = dst;
              m_words  = 0;
              m_req    = cyc + 1;
              m_commit = -1;
            end
          end else if (cyc == m_commit) begin
            m_act = 1'b0;
          end else if (cyc == m_req) begin
            m_wait = 1'b1;
          end else if (m_wait && mem_rd_valid) begin
            m_img[m_words] = mem_rd_data;
            m_words++;
            m_wait = 1'b0;
            if (m_words == WORDS) m_commit = cyc + 1;
            else m_req = cyc + 1;
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #3;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wbm", 32'(wbm), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset wbm_data", 32'(wbm_data[31:0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic load, L=1
    lat = 1;
    n0 = wbm_n; r0 = rq_addr.size(); t0 = cyc + 2;
    pulse_start(t0, 16'h0100, 2'd1);
    wait_wbm(n0 + 1, "t1 load");
    chk("t1 commit cycle", wbm_cyc - t0, 32'd193);
    chk("t1 wbm_addr", 32'(wbm_a), 32'd1);
    chk("t1 word0", 32'(wbm_d[15:0]), 32'h0100);
    chk("t1 word95", 32'(wbm_d[1535:1520]), 32'h015F);
    chk("t1 req count", rq_addr.size() - r0, 32'd96);
    chk("t1 first req cyc", qc(r0) - t0, 32'd1);
    chk("t1 last req cyc", qc(r0 + 95) - t0, 32'd191);
    chk("t1 last req addr", 32'(qa(r0 + 95)), 32'h015F);

    // L=3 with address wrap
    lat = 3;
    n0 = wbm_n; r0 = rq_addr.size(); t0 = cyc + 3;
    pulse_start(t0, 16'hFFF0, 2'd2);
    wait_wbm(n0 + 1, "t2 load");
    chk("t2 commit cycle", wbm_cyc - t0, 32'd385);
    chk("t2 wbm_addr", 32'(wbm_a), 32'd2);
    chk("t2 addr0", 32'(qa(r0)), 32'hFFF0);
    chk("t2 addr15", 32'(qa(r0 + 15)), 32'hFFFF);
    chk("t2 addr16", 32'(qa(r0 + 16)), 32'h0000);
    chk("t2 addr95", 32'(qa(r0 + 95)), 32'h004F);
    at_cycle(t0 + 386);
    #3;
    chk("t2 busy after", 32'(busy), 32'd0);

    // start while busy
    lat = 1;
    n0 = wbm_n; r0 = rq_addr.size(); t0 = cyc + 3;
    pulse_start(t0, 16'h0300, 2'd1);
    pulse_start(t0 + 50, 16'h0900, 2'd0);
    pulse_start(t0 + 193, 16'h0900, 2'd0);
    pulse_start(t0 + 194, 16'h0400, 2'd0);
    #3;
    chk("t3 busy at 195", 32'(busy), 32'd1);
    chk("t3 first wbm count", wbm_n - n0, 32'd1);
    chk("t3 first commit", wbm_cyc - t0, 32'd193);
    chk("t3 first wbm_addr", 32'(wbm_a), 32'd1);
    chk("t3 first word0", 32'(wbm_d[15:0]), 32'h0300);
    wait_wbm(n0 + 2, "t3 second load");
    chk("t3 second commit", wbm_cyc - (t0 + 194), 32'd193);
    chk("t3 second wbm_addr", 32'(wbm_a), 32'd0);
    chk("t3 second word0", 32'(wbm_d[15:0]), 32'h0400);
    chk("t3 req count", rq_addr.size() - r0, 32'd192);

    // reset mid-load with a late response in flight (L=2)
    lat = 2;
    n0 = wbm_n; t0 = cyc + 3;
    pulse_start(t0, 16'h0500, 2'd1);
    at_cycle(t0 + 80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("t4 busy after rst", 32'(busy), 32'd0);
    chk("t4 rd_en after rst", 32'(mem_rd_en), 32'd0);
    at_cycle(t0 + 150);
    chk("t4 no wbm", wbm_n - n0, 32'd0);
    lat = 1;
    n0 = wbm_n; r0 = rq_addr.size(); t1 = cyc + 2;
    pulse_start(t1, 16'h0200, 2'd0);
    wait_wbm(n0 + 1, "t4 reload");
    chk("t4 commit cycle", wbm_cyc - t1, 32'd193);
    chk("t4 wbm_addr", 32'(wbm_a), 32'd0);
    chk("t4 word0", 32'(wbm_d[15:0]), 32'h0200);
    chk("t4 word95", 32'(wbm_d[1535:1520]), 32'h025F);
    chk("t4 req count", rq_addr.size() - r0, 32'd96);

    // invalid destination
    n0 = wbm_n; r0 = rq_addr.size(); t0 = cyc + 3;
    pulse_start(t0, 16'h0700, 2'd3);
    at_cycle(t0 + 21);
    #3;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 no reqs", rq_addr.size() - r0, 32'd0);
    chk("t5 no wbm", wbm_n - n0, 32'd0);

    // memory stall on word 10
    stall_on    = 1'b1;
    stall_addr  = 16'h080A;
    stall_extra = 49;
    n0 = wbm_n; r0 = rq_addr.size(); t0 = cyc + 3;
    pulse_start(t0, 16'h0800, 2'd2);
    wait_wbm(n0 + 1, "t6 load");
    stall_on = 1'b0;
    chk("t6 commit cycle", wbm_cyc - t0, 32'd242);
    chk("t6 word10 reqs", count_addr(r0, 16'h080A), 32'd1);
    chk("t6 word10", 32'(wbm_d[175:160]), 32'h080A);
    chk("t6 wbm_addr", 32'(wbm_a), 32'd2);
    chk("t6 req count", rq_addr.size() - r0, 32'd96);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
